// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, defaults and helpers for the MAC accumulator
// Contents: FSM state enum, K/GUARD/ACC_W/CNT_W defaults, sext_prod(), sat_max(), sat_min().
// Helpers work on a MAX_W-wide vector; callers size-cast the result to their own width.
package mac_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int K_DEF     = 32;
    localparam int GUARD_DEF = 8;
    localparam int ACC_W_DEF = 2 * K_DEF + GUARD_DEF;
    localparam int CNT_W_DEF = 16;

    localparam int MAX_W = 128;
    typedef logic [MAX_W-1:0] wide_t;

    // p carries a pw-bit two's-complement value in its low bits; replicate its sign upward
    function automatic wide_t sext_prod(input wide_t p, input int pw);
        wide_t sh;
        sh = p << (MAX_W - pw);
        return $signed(sh) >>> (MAX_W - pw);
    endfunction

    // Largest positive value of a w-bit signed number, in the low w bits
    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) << (w - 1)) - wide_t'(1);
    endfunction

    // Most negative value of a w-bit signed number, in the low w bits
    function automatic wide_t sat_min(input int w);
        return wide_t'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/mac_add_sat.sv
// rtl/mac_add_sat.sv - combinational signed adder with overflow flag and optional clamp
// Ports: a, b (W-bit signed addends), sum (W-bit result), ovf (signed overflow of a+b).
// Build option SAT_EN: clamp sum to the signed range on overflow; otherwise wrap.
module mac_add_sat
    import mac_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

`ifdef SAT_EN
    localparam logic [W-1:0] SAT_HI = W'(sat_max(W));
    localparam logic [W-1:0] SAT_LO = W'(sat_min(W));
`endif

    logic [W-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when both addends share a sign and the result flips it
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef SAT_EN
        // Direction of overflow follows the common addend sign
        if (ovf) begin
            sum = a[W-1] ? SAT_LO : SAT_HI;
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - burst accumulator of signed multiplier products with result handshake
// Ports: clk, rst_n (async active-low), clr (sync abort),
//        prod/prod_valid/prod_last/prod_ready (product beats in),
//        acc_out/acc_cnt/acc_ovf/acc_valid/acc_ready (burst result out).
// Build option SAT_EN: saturating accumulation (see mac_add_sat).
module mac_accum
    import mac_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [2*K-1:0]           prod,
    input  logic                     prod_valid,
    input  logic                     prod_last,
    output logic                     prod_ready,
    output logic [2*K+GUARD-1:0]     acc_out,
    output logic [CNT_W-1:0]         acc_cnt,
    output logic                     acc_ovf,
    output logic                     acc_valid,
    input  logic                     acc_ready
);

    localparam int ACC_W = 2 * K + GUARD;

    state_t             state;
    logic [ACC_W-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum_nxt;
    logic               add_ovf;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf_nxt;
    logic               beat;

    assign prod_ext = ACC_W'(sext_prod(wide_t'(prod), 2 * K));
    assign beat     = prod_valid && prod_ready;
    assign cnt_nxt  = cnt_q + CNT_W'(1);
    assign ovf_nxt  = ovf_q || add_ovf;

    mac_add_sat #(
        .W (ACC_W)
    ) u_add (
        .a   (sum_q),
        .b   (prod_ext),
        .sum (sum_nxt),
        .ovf (add_ovf)
    );

    // prod_ready is registered, so it reads 0 for the first cycle after reset release
    // and is already low in the cycle a HOLD is released (no overlap with a new beat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACC;
            sum_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            acc_out    <= '0;
            acc_cnt    <= '0;
            acc_ovf    <= 1'b0;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b0;
        end else if (clr) begin
            state      <= ACC;
            sum_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    prod_ready <= 1'b1;
                    if (beat) begin
                        sum_q <= sum_nxt;
                        cnt_q <= cnt_nxt;
                        ovf_q <= ovf_nxt;
                        if (prod_last) begin
                            acc_out    <= sum_nxt;
                            acc_cnt    <= cnt_nxt;
                            acc_ovf    <= ovf_nxt;
                            acc_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        acc_valid  <= 1'b0;
                        sum_q      <= '0;
                        cnt_q      <= '0;
                        ovf_q      <= 1'b0;
                        prod_ready <= 1'b1;
                        state      <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// tb/tb_mac_accum.sv - directed self-checking bench for mac_accum (K=4, GUARD=4, CNT_W=8)
module tb_mac_accum;

    localparam int K     = 4;
    localparam int GUARD = 4;
    localparam int CNT_W = 8;
    localparam int ACC_W = 2 * K + GUARD;

`ifdef SAT_EN
    localparam logic [ACC_W-1:0] EXP_BIG = 12'h7FF;
`else
    localparam logic [ACC_W-1:0] EXP_BIG = 12'h86F;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic [2*K-1:0]   prod;
    logic             prod_valid;
    logic             prod_last;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_ovf;
    logic             acc_valid;
    logic             acc_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accum #(
        .K     (K),
        .GUARD (GUARD),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_cnt    (acc_cnt),
        .acc_ovf    (acc_ovf),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase after acceptance
    task automatic send(input logic [2*K-1:0] p, input logic last);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        prod       = p;
        prod_valid = 1'b1;
        prod_last  = last;
        while (!done && n < 50) begin
            done = prod_ready;
            @(posedge clk);
            #1;
            n++;
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    // Waits for the result, checks it, and (with acc_ready=1) checks it lasts one cycle
    task automatic expect_result(input string tag, input logic [ACC_W-1:0] e_out,
                                 input logic [CNT_W-1:0] e_cnt, input logic e_ovf);
        int n;
        n = 0;
        while (!acc_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, 64'(acc_valid), 64'd1);
        check({tag, "_out"},   64'(acc_out),   64'(e_out));
        check({tag, "_cnt"},   64'(acc_cnt),   64'(e_cnt));
        check({tag, "_ovf"},   64'(acc_ovf),   64'(e_ovf));
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 64'(acc_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        prod       = '0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        acc_ready  = 1'b1;

        @(posedge clk);
        #1;
        check("rst_out",   64'(acc_out),    64'd0);
        check("rst_cnt",   64'(acc_cnt),    64'd0);
        check("rst_ovf",   64'(acc_ovf),    64'd0);
        check("rst_valid", 64'(acc_valid),  64'd0);
        check("rst_ready", 64'(prod_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready0", 64'(prod_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_ready1", 64'(prod_ready), 64'd1);

        // +12, -9, +16 -> 19
        send(8'h0C, 1'b0);
        send(8'hF7, 1'b0);
        send(8'h10, 1'b1);
        expect_result("burst3", 12'h013, 8'd3, 1'b0);
        check("burst3_ready_back", 64'(prod_ready), 64'd1);

        // Single beat -128 with consumer stalled for 5 cycles
        acc_ready = 1'b0;
        send(8'h80, 1'b1);
        check("single_cnt", 64'(acc_cnt), 64'd1);
        prod       = 8'h02;
        prod_valid = 1'b1;
        prod_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_ready", 64'(prod_ready), 64'd0);
            check("hold_valid", 64'(acc_valid),  64'd1);
            check("hold_out",   64'(acc_out),    64'hF80);
            @(posedge clk);
            #1;
        end
        acc_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", 64'(acc_valid),  64'd0);
        check("hold_release_ready", 64'(prod_ready), 64'd1);
        send(8'h03, 1'b1);
        expect_result("after_hold", 12'h003, 8'd1, 1'b0);

        // 17 x +127 overflows a 12-bit accumulator
        for (int i = 0; i < 17; i++) send(8'h7F, (i == 16));
        expect_result("ovf17", EXP_BIG, 8'd17, 1'b1);

        // prod_last without prod_valid must not end the burst
        send(8'h04, 1'b0);
        prod_valid = 1'b0;
        prod_last  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("last_no_valid", 64'(acc_valid), 64'd0);
        end
        prod_last = 1'b0;
        send(8'h06, 1'b1);
        expect_result("last_ign", 12'h00A, 8'd2, 1'b0);

        // clr on beat 3 with a valid beat present
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        prod       = 8'h40;
        prod_valid = 1'b1;
        clr        = 1'b1;
        @(posedge clk);
        #1;
        clr        = 1'b0;
        prod_valid = 1'b0;
        check("clr_valid", 64'(acc_valid), 64'd0);
        send(8'h05, 1'b1);
        expect_result("after_clr", 12'h005, 8'd1, 1'b0);

        // 256 beats: count wraps to 0, sum 0x100
        for (int i = 0; i < 256; i++) send(8'h01, (i == 255));
        expect_result("cnt_wrap", 12'h100, 8'd0, 1'b0);

        // Async reset mid-burst
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out",   64'(acc_out),    64'd0);
        check("arst_cnt",   64'(acc_cnt),    64'd0);
        check("arst_valid", 64'(acc_valid),  64'd0);
        check("arst_ready", 64'(prod_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel_ready0", 64'(prod_ready), 64'd0);
        @(posedge clk);
        #1;
        check("arst_rel_ready1", 64'(prod_ready), 64'd1);
        send(8'h07, 1'b1);
        expect_result("after_arst", 12'h007, 8'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
